// File: rtl/i2c_master_nb.sv
// Open-drain I2C master, 0..MAX_BYTES read/write per transaction; I2C_NACK_ABORT_EN aborts to STOP on a NACK.
// Latency: done at accept + (41+36*nbytes)*CLK_DIV cycles, plus any cycles SCL is held low by the slave.
// Backpressure: start is only sampled while busy=0; the slave can stall the bit clock by stretching SCL.
module i2c_master_nb #(
    parameter int  CLK_DIV   = 125,
    parameter int  MAX_BYTES = 4,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             addr_in,
    input  logic [CNT_W-1:0]       nbytes,
    input  logic [8*MAX_BYTES-1:0] data_in,
    inout  wire                    SDA,
    inout  wire                    SCL,
    output logic                   busy,
    output logic                   done,
    output logic                   nack,
    output logic [7:0]             rx_data,
    output logic                   rx_valid
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {IDLE, START, ADDR, ACK_A, WRITE, ACK_W, READ, ACK_R, STOP} state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div;
    logic [1:0]             q;
    logic [2:0]             bit_cnt;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       nb_l;
    logic [7:0]             shreg;
    logic [8*MAX_BYTES-1:0] data_l;
    logic                   rw_l;
    logic                   sda_oe;
    logic                   scl_oe;

    logic                   in_slot;
    logic                   stall;
    logic                   tick;
    logic                   smp;
    logic                   last_byte;
    logic                   abort;
    logic [CNT_W-1:0]       nxt_byte;

    assign SDA = sda_oe ? 1'b0 : 1'bz;
    assign SCL = scl_oe ? 1'b0 : 1'bz;

    always_comb begin
        in_slot   = (state == ADDR) || (state == ACK_A) || (state == WRITE) ||
                    (state == ACK_W) || (state == READ) || (state == ACK_R);
        // Slave stretching: SCL released by us but still reading low
        stall     = in_slot && (q == 2'd3) && !scl_oe && !SCL;
        tick      = !stall && (div == DIV_W'(CLK_DIV - 1));
        smp       = in_slot && (q == 2'd3) && (div == '0) && !stall;
        nxt_byte  = byte_cnt + 1'b1;
        last_byte = (nxt_byte == nb_l);
`ifdef I2C_NACK_ABORT_EN
        // The first NACK aborts at its own slot, so a set nack means this slot NACKed
        abort     = nack;
`else
        abort     = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            div      <= '0;
            q        <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            nb_l     <= '0;
            shreg    <= 8'd0;
            data_l   <= '0;
            rw_l     <= 1'b0;
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                div <= '0;
                if (start) begin
                    state    <= START;
                    q        <= 2'd0;
                    busy     <= 1'b1;
                    nack     <= 1'b0;
                    rw_l     <= rw;
                    shreg    <= {addr_in, rw};
                    data_l   <= data_in;
                    nb_l     <= (nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= '0;
                    sda_oe   <= 1'b0;
                    scl_oe   <= 1'b0;
                end
            end else begin
                if (!stall) div <= tick ? '0 : div + 1'b1;

                if (smp) begin
                    if ((state == ACK_A || state == ACK_W) && SDA) nack <= 1'b1;
                    if (state == READ) begin
                        shreg <= {shreg[6:0], SDA};
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {shreg[6:0], SDA};
                            rx_valid <= 1'b1;
                        end
                    end
                end

                if (tick) begin
                    case (state)
                        START: begin
                            if (q == 2'd0) begin
                                q      <= 2'd1;
                                sda_oe <= 1'b1;
                            end else begin
                                state  <= ADDR;
                                q      <= 2'd0;
                                scl_oe <= 1'b1;
                                sda_oe <= ~shreg[7];
                            end
                        end
                        STOP: begin
                            case (q)
                                2'd0: begin q <= 2'd1; scl_oe <= 1'b0; end
                                2'd1: begin q <= 2'd2; sda_oe <= 1'b0; end
                                default: begin
                                    state <= IDLE;
                                    q     <= 2'd0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end
                        default: begin
                            case (q)
                                2'd0: q <= 2'd1;
                                2'd1: begin q <= 2'd2; scl_oe <= 1'b0; end
                                2'd2: q <= 2'd3;
                                default: begin
                                    // Slot end: every successor (including STOP) opens with SCL low
                                    q      <= 2'd0;
                                    scl_oe <= 1'b1;
                                    case (state)
                                        ADDR, WRITE: begin
                                            if (bit_cnt == 3'd7) begin
                                                state   <= (state == ADDR) ? ACK_A : ACK_W;
                                                bit_cnt <= 3'd0;
                                                sda_oe  <= 1'b0;
                                            end else begin
                                                bit_cnt <= bit_cnt + 3'd1;
                                                shreg   <= {shreg[6:0], 1'b0};
                                                sda_oe  <= ~shreg[6];
                                            end
                                        end
                                        ACK_A: begin
                                            if (abort || nb_l == '0) begin
                                                state  <= STOP;
                                                sda_oe <= 1'b1;
                                            end else if (rw_l) begin
                                                state  <= READ;
                                                sda_oe <= 1'b0;
                                            end else begin
                                                state  <= WRITE;
                                                shreg  <= data_l[7:0];
                                                data_l <= data_l >> 8;
                                                sda_oe <= ~data_l[7];
                                            end
                                        end
                                        ACK_W: begin
                                            if (abort || last_byte) begin
                                                state  <= STOP;
                                                sda_oe <= 1'b1;
                                            end else begin
                                                state    <= WRITE;
                                                byte_cnt <= nxt_byte;
                                                shreg    <= data_l[7:0];
                                                data_l   <= data_l >> 8;
                                                sda_oe   <= ~data_l[7];
                                            end
                                        end
                                        READ: begin
                                            if (bit_cnt == 3'd7) begin
                                                state   <= ACK_R;
                                                bit_cnt <= 3'd0;
                                                sda_oe  <= ~last_byte;
                                            end else begin
                                                bit_cnt <= bit_cnt + 3'd1;
                                                sda_oe  <= 1'b0;
                                            end
                                        end
                                        ACK_R: begin
                                            if (last_byte) begin
                                                state  <= STOP;
                                                sda_oe <= 1'b1;
                                            end else begin
                                                state    <= READ;
                                                byte_cnt <= nxt_byte;
                                                sda_oe   <= 1'b0;
                                            end
                                        end
                                        default: begin
                                            state  <= STOP;
                                            sda_oe <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_nb.sv
// Directed bench for i2c_master_nb with a bus-level slave model on pulled-up SDA/SCL.
`timescale 1ns/1ps
module tb_i2c_master_nb;
    localparam int CD = 4;
    localparam int MB = 4;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          rw = 1'b0;
    logic [6:0]    addr_in = 7'd0;
    logic [CW-1:0] nbytes = '0;
    logic [8*MB-1:0] data_in = '0;
    wire           sda;
    wire           scl;
    logic          busy, done, nack, rx_valid;
    logic [7:0]    rx_data;

    logic s_sda_low = 1'b0;
    logic s_scl_low = 1'b0;
    logic stretch_win = 1'b0;

    assign sda = s_sda_low ? 1'b0 : 1'bz;
    assign scl = s_scl_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (scl);

    i2c_master_nb #(.CLK_DIV(CD), .MAX_BYTES(MB)) dut (
        .CLK(CLK), .RST(RST), .start(start), .rw(rw), .addr_in(addr_in),
        .nbytes(nbytes), .data_in(data_in), .SDA(sda), .SCL(scl),
        .busy(busy), .done(done), .nack(nack), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 CLK = ~CLK;

    // Slave model, sampled mid-cycle so simultaneous SDA/SCL moves are seen together
    int         frame = 0, cnt = 0, pulses = 0;
    logic       seen_rise = 1'b0, s_active = 1'b0, is_read = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] sh = 8'd0;
    logic [7:0] nack_mask = 8'd0;
    logic [7:0] rd_mem [0:3];
    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    logic [7:0] rx_q[$];

    always @(negedge CLK) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (!stretch_win) begin
            if (scl_p && !scl) begin
                if (seen_rise) pulses++;
                seen_rise = 1'b0;
                s_sda_low = 1'b0;
                if (s_active) begin
                    if (cnt == 8) begin
                        if ((frame == 0 || !is_read) && frame < 8)
                            s_sda_low = !nack_mask[3'(frame)];
                    end else if (is_read && frame >= 1 && frame <= 4) begin
                        s_sda_low = !rd_mem[2'(frame - 1)][3'(7 - cnt)];
                    end
                end
            end else if (!scl_p && scl) begin
                seen_rise = 1'b1;
                if (s_active) begin
                    if (cnt < 8) begin
                        sh = {sh[6:0], sda};
                        cnt++;
                    end else begin
                        bytes_q.push_back(sh);
                        acks_q.push_back(sda);
                        if (frame == 0) is_read = sh[0];
                        else if (is_read && sda) s_active = 1'b0;
                        frame++;
                        cnt = 0;
                    end
                end
            end else if (scl && scl_p && sda_p && !sda) begin
                s_active = 1'b1; frame = 0; cnt = 0; pulses = 0;
                seen_rise = 1'b0; is_read = 1'b0; s_sda_low = 1'b0;
            end else if (scl && scl_p && !sda_p && sda) begin
                s_active = 1'b0;
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic r, input logic [6:0] a, input logic [CW-1:0] n,
                          input logic [31:0] d);
        bytes_q.delete();
        acks_q.delete();
        rx_q.delete();
        @(negedge CLK);
        rw = r; addr_in = a; nbytes = n; data_in = d; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    // Edges counted from the accept edge's follower; -1 on timeout
    task automatic wait_done(output int n);
        n = 0;
        while (n < 4000) begin
            @(posedge CLK);
            #1 n++;
            if (done === 1'b1) return;
        end
        n = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h44;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sda", sda, 1'b1);
        chk("rst_scl", scl, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_nack", nack, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // Write 0x50, two bytes, all ACKed
        nack_mask = 8'h00;
        launch(1'b0, 7'h50, 3'd2, 32'h0000_3CA5);
        chk("wr_busy_after_accept", busy, 1'b1);
        wait_done(lat);
        chk("wr_latency", lat, 452);
        chk("wr_busy_at_done", busy, 1'b0);
        chk("wr_nack", nack, 1'b0);
        chk("wr_nbytes_on_bus", bytes_q.size(), 3);
        chk("wr_byte0", bytes_q[0], 8'hA0);
        chk("wr_byte1", bytes_q[1], 8'hA5);
        chk("wr_byte2", bytes_q[2], 8'h3C);
        @(posedge CLK);
        #1 chk("wr_done_one_cycle", done, 1'b0);

        // Read 0x51, three bytes
        launch(1'b1, 7'h51, 3'd3, 32'h0);
        wait_done(lat);
        chk("rd_latency", lat, 596);
        chk("rd_nack", nack, 1'b0);
        chk("rd_rx_count", rx_q.size(), 3);
        chk("rd_rx0", rx_q[0], 8'h11);
        chk("rd_rx1", rx_q[1], 8'h22);
        chk("rd_rx2", rx_q[2], 8'h33);
        chk("rd_ack_slots", acks_q.size(), 4);
        chk("rd_addr_byte", bytes_q[0], 8'hA3);
        chk("rd_master_ack0", acks_q[1], 1'b0);
        chk("rd_master_ack1", acks_q[2], 1'b0);
        chk("rd_master_nack_last", acks_q[3], 1'b1);

        // Address probe, slave NACKs
        nack_mask = 8'h01;
        launch(1'b0, 7'h50, 3'd0, 32'h0);
        wait_done(lat);
        chk("probe_latency", lat, 164);
        chk("probe_nack", nack, 1'b1);
        chk("probe_scl_pulses", pulses, 9);

        // Four-byte write, slave NACKs byte 1
        nack_mask = 8'h04;
        launch(1'b0, 7'h50, 3'd4, 32'h4433_2211);
        chk("nackw_nack_cleared_at_accept", nack, 1'b0);
        wait_done(lat);
        chk("nackw_nack", nack, 1'b1);
        chk("nackw_byte2", bytes_q[2], 8'h22);
`ifdef I2C_NACK_ABORT_EN
        chk("nackw_latency", lat, 452);
        chk("nackw_nbytes_on_bus", bytes_q.size(), 3);
`else
        chk("nackw_latency", lat, 740);
        chk("nackw_nbytes_on_bus", bytes_q.size(), 5);
        chk("nackw_byte4", bytes_q[4], 8'h44);
`endif

        // nbytes above MAX_BYTES clamps to four
        nack_mask = 8'h00;
        launch(1'b0, 7'h50, 3'd7, 32'h4433_2211);
        chk("clamp_nack_cleared", nack, 1'b0);
        wait_done(lat);
        chk("clamp_latency", lat, 740);
        chk("clamp_nbytes_on_bus", bytes_q.size(), 5);
        chk("clamp_byte4", bytes_q[4], 8'h44);

        // Slave stretches SCL for 20 cycles in Q3 of address bit 3
        launch(1'b0, 7'h50, 3'd2, 32'h0000_3CA5);
        repeat (68) @(posedge CLK);
        #1 stretch_win = 1'b1;
        s_scl_low = 1'b1;
        repeat (20) @(posedge CLK);
        #1 s_scl_low = 1'b0;
        @(posedge CLK);
        #1 stretch_win = 1'b0;
        wait_done(lat);
        chk("stretch_latency", (lat < 0) ? lat : lat + 89, 472);
        chk("stretch_byte0", bytes_q[0], 8'hA0);
        chk("stretch_byte1", bytes_q[1], 8'hA5);
        chk("stretch_byte2", bytes_q[2], 8'h3C);

        // Reset in the middle of a write whose byte 0 was NACKed
        nack_mask = 8'h02;
        launch(1'b0, 7'h50, 3'd2, 32'h0000_3CA5);
        repeat (300) @(posedge CLK);
        #1;
        chk("mid_nack_before_rst", nack, 1'b1);
        chk("mid_busy_before_rst", busy, 1'b1);
        RST = 1'b1;
        #1;
        chk("mid_rst_sda", sda, 1'b1);
        chk("mid_rst_scl", scl, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_nack", nack, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        nack_mask = 8'h00;
        repeat (2) @(posedge CLK);
        launch(1'b0, 7'h50, 3'd2, 32'h0000_3CA5);
        wait_done(lat);
        chk("post_rst_latency", lat, 452);
        chk("post_rst_nack", nack, 1'b0);
        chk("post_rst_nbytes_on_bus", bytes_q.size(), 3);
        chk("post_rst_byte2", bytes_q[2], 8'h3C);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
